icache_fetch_ctrl: RTL
======================

# icache_fetch_ctrl

Sequencing controller between the scalar fetch stage and the instruction cache. It accepts one fetch request at a time, issues it to the icache with a valid/ready handshake, and tracks the outstanding access. It drops responses made stale by a PC redirect, retries accesses that time out, and serialises full-icache invalidations against in-flight fetches. It returns one registered instruction word or exception per request to the fetch stage and drives that stage's stall.

## Interface
Parameters:
- ADDR_SIZE, 40, virtual fetch address width
- TIMEOUT, 64, cycles in WAIT before a retry (≥2)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- fetch_req_i  in  1  fetch stage requests the word at fetch_addr_i
- fetch_addr_i  in  ADDR_SIZE  fetch virtual address
- flush_i  in  1  PC redirect; any outstanding access becomes stale
- invalidate_icache_i  in  1  request full icache invalidation (pulse)
- icache_ready_i  in  1  icache accepts request/invalidate this cycle; low while busy
- icache_resp_valid_i  in  1  response valid
- icache_resp_data_i  in  32  instruction word
- icache_resp_xcpt_i  in  1  page fault on this response
- icache_req_valid_o  out  1  request valid
- icache_req_addr_o  out  ADDR_SIZE  latched request address
- icache_inval_o  out  1  invalidate command
- icache_kill_o  out  1  abort outstanding access
- fetch_valid_o  out  1  one-cycle pulse, word/exception delivered
- fetch_data_o  out  32  delivered word
- fetch_xcpt_o  out  1  delivered page fault
- fetch_stall_o  out  1  fetch stage must hold PC
- retry_o  out  1  one-cycle pulse on timeout retry

## Operation
- States: IDLE, REQ, WAIT, KILL, INVAL, INVAL_WAIT.
- inval_pend is set by invalidate_icache_i in any state. It is cleared on entering INVAL.
- IDLE transitions, in priority order:
  - inval_pend or invalidate_icache_i → INVAL.
  - fetch_req_i && !flush_i → REQ. addr_q is loaded from fetch_addr_i.
- REQ: icache_req_valid_o=1 and icache_req_addr_o=addr_q.
  - ready && flush_i → KILL.
  - ready → WAIT.
  - flush_i → IDLE.
  - Otherwise stay in REQ.
- WAIT transitions:
  - resp_valid && flush_i → IDLE. The response is discarded.
  - resp_valid → IDLE. Data and xcpt are registered into the fetch outputs and fetch_valid_o pulses.
  - flush_i → KILL.
  - Timeout counter == TIMEOUT-1 → REQ with the same addr_q. icache_kill_o and retry_o pulse for that cycle.
- KILL: icache_kill_o=1 for the first cycle only.
  - Waits for resp_valid, which is discarded, or TIMEOUT cycles, then → IDLE.
- INVAL: icache_inval_o=1; on icache_ready_i → INVAL_WAIT.
- INVAL_WAIT: waits for icache_ready_i high on a later cycle, then → IDLE.
- icache_resp_valid_i outside WAIT/KILL is ignored.
- Timeout counter: width $clog2(TIMEOUT).
  - Cleared on entry to WAIT/KILL.
  - Increments each cycle in those states.
  - Saturates; never wraps.
- fetch_stall_o = (state != IDLE) | inval_pend. This output is combinational.

## Timing
- Reset (rstn_i low at a clock edge):
  - State is IDLE.
  - All outputs are 0, including addr_q and fetch_data_o.
  - inval_pend and the counter are 0.
  - Reset mid-access abandons the access; no kill is issued.
- fetch_req_i sampled in IDLE at cycle N → icache_req_valid_o high at N+1.
- Response sampled in WAIT at cycle M → fetch_valid_o high at M+1 for exactly one cycle.
- Minimum request-to-delivery latency is 3 cycles (zero-wait icache). Throughput is one word per 3 cycles.
- icache_req_valid_o, once high, stays high with a stable address until accepted or flushed.
- flush_i and resp_valid in the same WAIT cycle: flush wins, and there is no fetch_valid_o.
- invalidate_icache_i during WAIT: the access completes normally, then INVAL is entered from IDLE.

## Configuration
- FETCH_TIMEOUT_EN defined: timeout counter, retry path and KILL timeout exit are implemented as described.
- FETCH_TIMEOUT_EN undefined:
  - No counter.
  - WAIT and KILL wait indefinitely for icache_resp_valid_i.
  - retry_o is tied 0, and icache_kill_o only pulses on entry to KILL.

## Test plan
- Reset held 2 cycles, then fetch_req_i with addr 0x80000000 and ready=1. Expected: req_valid at cycle 1 with that address; resp 0x00000013 two cycles later; fetch_valid_o pulses once with data 0x00000013.
- Icache stalls ready=0 for 5 cycles. Expected: req_valid and address stable throughout; acceptance on the 6th cycle; normal delivery.
- flush_i on the cycle resp_valid=1 in WAIT. Expected: no fetch_valid_o; state IDLE next cycle; next request is issued with the new address.
- flush_i in WAIT before the response. Expected: kill pulse; the late resp 0xDEADBEEF is swallowed; fetch_valid_o stays 0.
- invalidate_icache_i during WAIT. Expected: current word delivered; then icache_inval_o asserted; fetch_stall_o high until INVAL_WAIT completes; the pending fetch_req_i is issued after.
- With FETCH_TIMEOUT_EN and TIMEOUT=8, no response. Expected: retry_o and kill pulse after 8 WAIT cycles; request reissued with the same address; a response then delivers normally.

Source files
------------

// File: rtl/icache_fetch_ctrl.sv
// Purpose : sequences one fetch request at a time into the icache, drops stale responses
//           after a redirect, retries timed-out accesses, and serialises full invalidations.
// Latency : fetch_req_i sampled in IDLE -> icache_req_valid_o next cycle; minimum 3 cycles to fetch_valid_o.
// Backpr. : icache_req_valid_o and its address hold until icache_ready_i; fetch_stall_o holds the PC.
//
// Ports:
//   clk_i, rstn_i                 clock, synchronous active-low reset
//   fetch_req_i, fetch_addr_i     request from the fetch stage
//   flush_i                       PC redirect, makes any outstanding access stale
//   invalidate_icache_i           pulse requesting a full icache invalidation
//   icache_ready_i                icache accepts a request/invalidate this cycle
//   icache_resp_*_i               response word and page-fault flag
//   icache_req_valid_o/addr_o     request to the icache
//   icache_inval_o, icache_kill_o invalidate command, abort of the outstanding access
//   fetch_valid_o/data_o/xcpt_o   registered delivery back to the fetch stage
//   fetch_stall_o                 fetch stage must hold its PC
//   retry_o                       pulse when a timed-out access is reissued
//
// Build option: define FETCH_TIMEOUT_EN to include the timeout counter, retry path and KILL timeout exit.

module icache_fetch_ctrl #(
    parameter int ADDR_SIZE = 40,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 fetch_req_i,
    input  logic [ADDR_SIZE-1:0] fetch_addr_i,
    input  logic                 flush_i,
    input  logic                 invalidate_icache_i,
    input  logic                 icache_ready_i,
    input  logic                 icache_resp_valid_i,
    input  logic [31:0]          icache_resp_data_i,
    input  logic                 icache_resp_xcpt_i,
    output logic                 icache_req_valid_o,
    output logic [ADDR_SIZE-1:0] icache_req_addr_o,
    output logic                 icache_inval_o,
    output logic                 icache_kill_o,
    output logic                 fetch_valid_o,
    output logic [31:0]          fetch_data_o,
    output logic                 fetch_xcpt_o,
    output logic                 fetch_stall_o,
    output logic                 retry_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_KILL,
        S_INVAL,
        S_INVAL_WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 inval_pend_q, inval_pend_d;
    logic                 kill_first_q, kill_first_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic [31:0]          fetch_data_q, fetch_data_d;
    logic                 fetch_xcpt_q, fetch_xcpt_d;
    logic                 tmo_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cleared on any state change (covers entry into WAIT and KILL), counts while
    // resident in WAIT/KILL and saturates at TIMEOUT-1 instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_WAIT || state_q == S_KILL) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tmo_hit = (cnt_q == CNT_MAX);
`else
    // No timeout hardware: WAIT and KILL wait for a response indefinitely.
    // TIMEOUT has no effect here; the comparison is always false.
    assign tmo_hit = (TIMEOUT < 0);
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (inval_pend_q || invalidate_icache_i) state_d = S_INVAL;
                else if (fetch_req_i && !flush_i)        state_d = S_REQ;
            end
            S_REQ: begin
                // Accepted in the same cycle as a redirect: the icache owns a stale access.
                if (icache_ready_i && flush_i) state_d = S_KILL;
                else if (icache_ready_i)       state_d = S_WAIT;
                else if (flush_i)              state_d = S_IDLE;
            end
            S_WAIT: begin
                if (icache_resp_valid_i) state_d = S_IDLE;
                else if (flush_i)        state_d = S_KILL;
                else if (tmo_hit)        state_d = S_REQ;
            end
            S_KILL: begin
                if (icache_resp_valid_i || tmo_hit) state_d = S_IDLE;
            end
            S_INVAL: begin
                if (icache_ready_i) state_d = S_INVAL_WAIT;
            end
            S_INVAL_WAIT: begin
                if (icache_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and bookkeeping registers
    always_comb begin
        addr_d        = addr_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        fetch_xcpt_d  = fetch_xcpt_q;
        if (state_q == S_IDLE && state_d == S_REQ) addr_d = fetch_addr_i;
        // A flush in the response cycle makes the word stale; it is not delivered.
        if (state_q == S_WAIT && icache_resp_valid_i && !flush_i) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = icache_resp_data_i;
            fetch_xcpt_d  = icache_resp_xcpt_i;
        end
        if (state_d == S_INVAL && state_q != S_INVAL) inval_pend_d = 1'b0;
        else                                          inval_pend_d = inval_pend_q | invalidate_icache_i;
        kill_first_d = (state_d == S_KILL) && (state_q != S_KILL);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q        <= '0;
            inval_pend_q  <= 1'b0;
            kill_first_q  <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_xcpt_q  <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            inval_pend_q  <= inval_pend_d;
            kill_first_q  <= kill_first_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_xcpt_q  <= fetch_xcpt_d;
        end
    end

    // Output logic
    always_comb begin
        icache_req_valid_o = (state_q == S_REQ);
        icache_inval_o     = (state_q == S_INVAL);
        // Retry fires only when the timeout is the winning WAIT exit.
        retry_o            = (state_q == S_WAIT) && !icache_resp_valid_i && !flush_i && tmo_hit;
        icache_kill_o      = ((state_q == S_KILL) && kill_first_q) || retry_o;
        fetch_stall_o      = (state_q != S_IDLE) || inval_pend_q;
    end

    assign icache_req_addr_o = addr_q;
    assign fetch_valid_o     = fetch_valid_q;
    assign fetch_data_o      = fetch_data_q;
    assign fetch_xcpt_o      = fetch_xcpt_q;

endmodule
